// File: rtl/riscv_v_csr_file.sv
// Vector CSR storage: vsstatus.VS, vtype, vl, vstart, vxrm, vxsat with address-decoded reads.
// Define RISCV_V_CSR_BYPASS_EN to forward same-cycle writes to rd_data and the live outputs.
module riscv_v_csr_file #(
  parameter int XLEN = 32,
  parameter int VLEN = 128,
  parameter int VL_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_wr_en_vsstatus_wb,
  input  logic            csr_wr_en_vtype_wb,
  input  logic            csr_wr_en_vl_wb,
  input  logic            csr_wr_en_vstart_wb,
  input  logic            csr_wr_en_vxrm_wb,
  input  logic            csr_wr_en_vxsat_wb,
  input  logic [1:0]      csr_wr_data_vsstatus_wb,
  input  logic [XLEN-1:0] csr_wr_data_vtype_wb,
  input  logic [VL_W-1:0] csr_wr_data_vl_wb,
  input  logic [VL_W-1:0] csr_wr_data_vstart_wb,
  input  logic [1:0]      csr_wr_data_vxrm_wb,
  input  logic            csr_wr_data_vxsat_wb,
  input  logic            vxsat_set,
  input  logic            vstart_clr,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  output logic [XLEN-1:0] vtype_o,
  output logic [VL_W-1:0] vl_o,
  output logic [VL_W-1:0] vstart_o,
  output logic [1:0]      vxrm_o,
  output logic            vxsat_o,
  output logic [1:0]      vs_state_o
);

  localparam logic [XLEN-1:0] VTYPE_RST = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] VLENB     = XLEN'(VLEN / 8);
  localparam logic [1:0]      VS_INIT   = 2'd1;
  localparam logic [1:0]      VS_DIRTY  = 2'd3;

  logic [XLEN-1:0] vtype_q, vtype_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VL_W-1:0] vstart_q, vstart_d;
  logic [1:0]      vxrm_q, vxrm_d;
  logic            vxsat_q, vxsat_d;
  logic [1:0]      vs_q, vs_d;
  logic            vtype_illegal;
  logic            dirty;

  always_comb begin
    vtype_illegal = csr_wr_data_vtype_wb[XLEN-1]
                  | (|csr_wr_data_vtype_wb[XLEN-2:8])
                  | (csr_wr_data_vtype_wb[2:0] == 3'b100)
                  | (csr_wr_data_vtype_wb[5:3] > 3'b011);

    vtype_d = vtype_q;
    if (csr_wr_en_vtype_wb) vtype_d = vtype_illegal ? VTYPE_RST : csr_wr_data_vtype_wb;

    vl_d = csr_wr_en_vl_wb ? csr_wr_data_vl_wb : vl_q;

    vstart_d = vstart_q;
    if (csr_wr_en_vstart_wb) vstart_d = csr_wr_data_vstart_wb;
    else if (vstart_clr)     vstart_d = '0;

    vxrm_d = csr_wr_en_vxrm_wb ? csr_wr_data_vxrm_wb : vxrm_q;

    vxsat_d = vxsat_q;
    if (csr_wr_en_vxsat_wb) vxsat_d = csr_wr_data_vxsat_wb;
    else if (vxsat_set)     vxsat_d = 1'b1;

    // vstart_clr is a normal end-of-instruction event and must not dirty the state.
    dirty = csr_wr_en_vtype_wb | csr_wr_en_vl_wb | csr_wr_en_vstart_wb
          | csr_wr_en_vxrm_wb | csr_wr_en_vxsat_wb | vxsat_set;

    vs_d = vs_q;
    if (csr_wr_en_vsstatus_wb) vs_d = csr_wr_data_vsstatus_wb;
    else if (dirty)            vs_d = VS_DIRTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vtype_q  <= VTYPE_RST;
      vl_q     <= '0;
      vstart_q <= '0;
      vxrm_q   <= '0;
      vxsat_q  <= 1'b0;
      vs_q     <= VS_INIT;
    end else begin
      vtype_q  <= vtype_d;
      vl_q     <= vl_d;
      vstart_q <= vstart_d;
      vxrm_q   <= vxrm_d;
      vxsat_q  <= vxsat_d;
      vs_q     <= vs_d;
    end
  end

`ifdef RISCV_V_CSR_BYPASS_EN
  assign vtype_o  = vtype_d;
  assign vl_o     = vl_d;
  assign vstart_o = vstart_d;
  assign vxrm_o   = vxrm_d;
  assign vxsat_o  = vxsat_d;
`else
  assign vtype_o  = vtype_q;
  assign vl_o     = vl_q;
  assign vstart_o = vstart_q;
  assign vxrm_o   = vxrm_q;
  assign vxsat_o  = vxsat_q;
`endif
  // VS is never forwarded; it always reflects the stored state.
  assign vs_state_o = vs_q;

  always_comb begin
    rd_data    = '0;
    rd_illegal = 1'b0;
    case (rd_addr)
      12'h008: rd_data = {{(XLEN-VL_W){1'b0}}, vstart_o};
      12'h009: rd_data = {{(XLEN-1){1'b0}}, vxsat_o};
      12'h00A: rd_data = {{(XLEN-2){1'b0}}, vxrm_o};
      12'h00F: rd_data = {{(XLEN-3){1'b0}}, vxrm_o, vxsat_o};
      12'hC20: rd_data = {{(XLEN-VL_W){1'b0}}, vl_o};
      12'hC21: rd_data = vtype_o;
      12'hC22: rd_data = VLENB;
      default: rd_illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscv_v_csr_file.sv
// Self-checking bench for riscv_v_csr_file: directed cases plus randomized traffic vs a reference model.
module tb_riscv_v_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_vs, en_vtype, en_vl, en_vstart, en_vxrm, en_vxsat;
  logic [1:0]  d_vs;
  logic [31:0] d_vtype;
  logic [7:0]  d_vl, d_vstart;
  logic [1:0]  d_vxrm;
  logic        d_vxsat;
  logic        vxsat_set, vstart_clr;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic [31:0] vtype_o;
  logic [7:0]  vl_o, vstart_o;
  logic [1:0]  vxrm_o;
  logic        vxsat_o;
  logic [1:0]  vs_state_o;

  int checks = 0;
  int errors = 0;

  // reference model: committed state (m_*) and state after the pending cycle (n_*)
  logic [31:0] m_vtype, n_vtype;
  logic [7:0]  m_vl, n_vl, m_vstart, n_vstart;
  logic [1:0]  m_vxrm, n_vxrm, m_vs, n_vs;
  logic        m_vxsat, n_vxsat;

  riscv_v_csr_file #(.XLEN(32), .VLEN(128), .VL_W(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .csr_wr_en_vsstatus_wb   (en_vs),
    .csr_wr_en_vtype_wb      (en_vtype),
    .csr_wr_en_vl_wb         (en_vl),
    .csr_wr_en_vstart_wb     (en_vstart),
    .csr_wr_en_vxrm_wb       (en_vxrm),
    .csr_wr_en_vxsat_wb      (en_vxsat),
    .csr_wr_data_vsstatus_wb (d_vs),
    .csr_wr_data_vtype_wb    (d_vtype),
    .csr_wr_data_vl_wb       (d_vl),
    .csr_wr_data_vstart_wb   (d_vstart),
    .csr_wr_data_vxrm_wb     (d_vxrm),
    .csr_wr_data_vxsat_wb    (d_vxsat),
    .vxsat_set               (vxsat_set),
    .vstart_clr              (vstart_clr),
    .rd_addr                 (rd_addr),
    .rd_data                 (rd_data),
    .rd_illegal              (rd_illegal),
    .vtype_o                 (vtype_o),
    .vl_o                    (vl_o),
    .vstart_o                (vstart_o),
    .vxrm_o                  (vxrm_o),
    .vxsat_o                 (vxsat_o),
    .vs_state_o              (vs_state_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    en_vs = 0; en_vtype = 0; en_vl = 0; en_vstart = 0; en_vxrm = 0; en_vxsat = 0;
    d_vs = 0; d_vtype = 0; d_vl = 0; d_vstart = 0; d_vxrm = 0; d_vxsat = 0;
    vxsat_set = 0; vstart_clr = 0;
  endtask

  task automatic model_reset();
    m_vtype = 32'h8000_0000; m_vl = 0; m_vstart = 0; m_vxrm = 0; m_vxsat = 0; m_vs = 2'd1;
  endtask

  // Architectural rules applied to the currently driven inputs.
  task automatic model_next();
    bit legal;
    legal = (d_vtype[31] == 1'b0) && (d_vtype[30:8] == 23'd0)
         && (d_vtype[2:0] != 3'd4) && (d_vtype[5:3] <= 3'd3);
    n_vtype  = en_vtype ? (legal ? d_vtype : 32'h8000_0000) : m_vtype;
    n_vl     = en_vl ? d_vl : m_vl;
    n_vstart = en_vstart ? d_vstart : (vstart_clr ? 8'd0 : m_vstart);
    n_vxrm   = en_vxrm ? d_vxrm : m_vxrm;
    n_vxsat  = en_vxsat ? d_vxsat : (vxsat_set ? 1'b1 : m_vxsat);
    if (en_vs) n_vs = d_vs;
    else if (en_vtype || en_vl || en_vstart || en_vxrm || en_vxsat || vxsat_set) n_vs = 2'd3;
    else n_vs = m_vs;
  endtask

  function automatic logic [32:0] exp_read(input logic [11:0] a, input logic [31:0] vt,
                                           input logic [7:0] vl, input logic [7:0] vst,
                                           input logic [1:0] xrm, input logic xsat);
    logic [31:0] v;
    v = 0;
    case (a)
      12'h008: v = 32'(vst);
      12'h009: v = 32'(xsat);
      12'h00A: v = 32'(xrm);
      12'h00F: v = 32'(xrm) * 2 + 32'(xsat);
      12'hC20: v = 32'(vl);
      12'hC21: v = vt;
      12'hC22: v = 32'd16;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, v};
  endfunction

  task automatic clk_cycle();
    model_next();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_vtype = n_vtype; m_vl = n_vl; m_vstart = n_vstart;
      m_vxrm = n_vxrm; m_vxsat = n_vxsat; m_vs = n_vs;
    end
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1; clk_cycle(); clk_cycle(); rst = 0;
    rd_addr = 12'hC21; #1; checks++;
    if (rd_data !== 32'h8000_0000) begin errors++; $display("FAIL reset_vtype got %h exp 80000000", rd_data); end
    rd_addr = 12'hC20; #1; checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_vl got %h exp 0", rd_data); end
    rd_addr = 12'hC22; #1; checks++;
    if (rd_data !== 32'd16) begin errors++; $display("FAIL reset_vlenb got %h exp 10", rd_data); end
    checks++;
    if (vs_state_o !== 2'd1) begin errors++; $display("FAIL reset_vs got %0d exp 1", vs_state_o); end
    checks++;
    if ({vstart_o, vxrm_o, vxsat_o, rd_illegal} !== 12'd0)
      begin errors++; $display("FAIL reset_misc got %h exp 0", {vstart_o, vxrm_o, vxsat_o, rd_illegal}); end
  endtask

  task automatic test_vtype();
    logic [31:0] pats [5] = '{32'h0000_0011, 32'h0000_0004, 32'h0000_0100, 32'h0000_0020, 32'h8000_0011};
    logic [31:0] exps [5] = '{32'h0000_0011, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      en_vtype = 1; d_vtype = pats[i]; clk_cycle();
      rd_addr = 12'hC21; #1; checks++;
      if (rd_data !== exps[i] || vtype_o !== exps[i])
        begin errors++; $display("FAIL vtype_%0d got %h/%h exp %h", i, rd_data, vtype_o, exps[i]); end
    end
    checks++;
    if (vs_state_o !== 2'd3) begin errors++; $display("FAIL vtype_dirty got %0d exp 3", vs_state_o); end
  endtask

  task automatic test_vxsat();
    vxsat_set = 1; clk_cycle();
    rd_addr = 12'h009; #1; checks++;
    if (rd_data !== 32'd1) begin errors++; $display("FAIL vxsat_set got %h exp 1", rd_data); end
    rd_addr = 12'h00F; #1; checks++;
    if (rd_data !== 32'd1) begin errors++; $display("FAIL vcsr_1 got %h exp 1", rd_data); end
    en_vxrm = 1; d_vxrm = 2; clk_cycle();
    rd_addr = 12'h00F; #1; checks++;
    if (rd_data !== 32'd5) begin errors++; $display("FAIL vcsr_5 got %h exp 5", rd_data); end
    en_vxsat = 1; d_vxsat = 0; vxsat_set = 1; clk_cycle();
    rd_addr = 12'h009; #1; checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL vxsat_wr_prio got %h exp 0", rd_data); end
  endtask

  task automatic test_vstart();
    en_vstart = 1; d_vstart = 5; vstart_clr = 1; clk_cycle();
    rd_addr = 12'h008; #1; checks++;
    if (rd_data !== 32'd5) begin errors++; $display("FAIL vstart_prio got %h exp 5", rd_data); end
    en_vs = 1; d_vs = 2; clk_cycle();
    vstart_clr = 1; clk_cycle();
    rd_addr = 12'h008; #1; checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL vstart_clr got %h exp 0", rd_data); end
    checks++;
    if (vs_state_o !== 2'd2) begin errors++; $display("FAIL vstart_clr_vs got %0d exp 2", vs_state_o); end
  endtask

  task automatic test_vs_read();
    en_vs = 1; d_vs = 2; en_vl = 1; d_vl = 8; clk_cycle();
    rd_addr = 12'hC20; #1; checks++;
    if (vs_state_o !== 2'd2 || rd_data !== 32'd8)
      begin errors++; $display("FAIL vs_vl got vs=%0d vl=%h exp vs=2 vl=8", vs_state_o, rd_data); end
    rd_addr = 12'h123; #1; checks++;
    if (rd_illegal !== 1'b1 || rd_data !== 32'd0)
      begin errors++; $display("FAIL illegal_addr got ill=%b data=%h exp ill=1 data=0", rd_illegal, rd_data); end
    en_vl = 1; d_vl = 200; clk_cycle();
    rd_addr = 12'hC20; #1; checks++;
    if (rd_data !== 32'd200) begin errors++; $display("FAIL vl_noclamp got %0d exp 200", rd_data); end
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    en_vl = 1; d_vl = 9; rd_addr = 12'hC20; #1;
`ifdef RISCV_V_CSR_BYPASS_EN
    exp = 32'd9;
`else
    exp = 32'(m_vl);
`endif
    checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL same_cycle_vl got %0d exp %0d", rd_data, exp); end
    clk_cycle(); #1; checks++;
    if (rd_data !== 32'd9) begin errors++; $display("FAIL next_cycle_vl got %0d exp 9", rd_data); end
  endtask

  task automatic test_reset_mid_write();
    en_vs = 1; d_vs = 3; en_vtype = 1; d_vtype = 32'h11; en_vl = 1; d_vl = 77;
    en_vstart = 1; d_vstart = 3; en_vxrm = 1; d_vxrm = 3; en_vxsat = 1; d_vxsat = 1;
    rst = 1; clk_cycle(); rst = 0; #1; checks++;
    if ({vtype_o, vl_o, vstart_o, vxrm_o, vxsat_o, vs_state_o} !== {32'h8000_0000, 8'd0, 8'd0, 2'd0, 1'b0, 2'd1})
      begin errors++; $display("FAIL reset_mid_write got %h %h %h %h %h %h", vtype_o, vl_o, vstart_o, vxrm_o, vxsat_o, vs_state_o); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [8] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22, 12'h000};
    logic [31:0] r;
    logic [32:0] e;
    logic [31:0] e_vt; logic [7:0] e_vl, e_vst; logic [1:0] e_xrm; logic e_xs;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      en_vs = (r[2:0] == 0); en_vtype = (r[5:3] < 2); en_vl = (r[8:6] < 2);
      en_vstart = (r[11:9] < 2); en_vxrm = (r[14:12] == 0); en_vxsat = (r[17:15] == 0);
      vxsat_set = (r[20:18] < 2); vstart_clr = (r[23:21] < 2);
      r = $urandom;
      d_vs = r[1:0]; d_vxrm = r[3:2]; d_vxsat = r[4]; d_vl = r[15:8]; d_vstart = r[23:16];
      r = $urandom;
      d_vtype = {24'd0, r[7:0]};
      if (r[10:8] == 0) d_vtype[31] = 1'b1;
      if (r[13:11] == 0) d_vtype[8 + 32'(r[18:14]) % 23] = 1'b1;
      r = $urandom;
      rd_addr = (r[3:0] < 4) ? r[27:16] : addrs[r[6:4]];
      #1;
      model_next();
`ifdef RISCV_V_CSR_BYPASS_EN
      e_vt = n_vtype; e_vl = n_vl; e_vst = n_vstart; e_xrm = n_vxrm; e_xs = n_vxsat;
`else
      e_vt = m_vtype; e_vl = m_vl; e_vst = m_vstart; e_xrm = m_vxrm; e_xs = m_vxsat;
`endif
      e = exp_read(rd_addr, e_vt, e_vl, e_vst, e_xrm, e_xs);
      checks++;
      if ({rd_illegal, rd_data} !== e)
        begin errors++; $display("FAIL rand_read_%0d addr %h got %b/%h exp %b/%h", i, rd_addr, rd_illegal, rd_data, e[32], e[31:0]); end
      checks++;
      if ({vtype_o, vl_o, vstart_o, vxrm_o, vxsat_o, vs_state_o} !== {e_vt, e_vl, e_vst, e_xrm, e_xs, m_vs})
        begin errors++; $display("FAIL rand_live_%0d got %h %h %h %h %h %h exp %h %h %h %h %h %h", i,
          vtype_o, vl_o, vstart_o, vxrm_o, vxsat_o, vs_state_o, e_vt, e_vl, e_vst, e_xrm, e_xs, m_vs); end
      clk_cycle();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1; rd_addr = 0;
    model_reset();
    test_reset();
    test_vtype();
    test_vxsat();
    test_vstart();
    test_vs_read();
    test_latency();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
